// File: rtl/sd_block_responder_if.sv
// Block-transfer bus between the core's sector buffer, the responder and the
// backing byte memory. The slave modport is the responder's view; the master
// modport is the environment's view (core buffer plus image memory).
interface sd_block_responder_if #(
  parameter int ADDR_W = 24
);
  logic [31:0]       sd_lba;
  logic              sd_rd;
  logic              sd_wr;
  logic              sd_ack;
  logic [8:0]        sd_buff_addr;
  logic [7:0]        sd_buff_dout;
  logic              sd_buff_wr;
  logic [7:0]        sd_buff_din;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ready;

  modport slave (
    input  sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
    output sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );

  modport master (
    output sd_lba, sd_rd, sd_wr, sd_buff_din, mem_rdata, mem_ready,
    input  sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
           mem_addr, mem_rd, mem_wr, mem_wdata
  );
endinterface

// File: rtl/sd_block_responder.sv
// Device-side responder for 512-byte sector requests, backed by a byte-wide
// image memory. Optional write protection is enabled with the macro
// SD_RESP_WRPROTECT_EN (adds the img_readonly input).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for sd_rd / sd_wr, latches lba and direction
// S_DLY     | ACK_DLY cycles before sd_ack, range check latched on exit
// S_RD_MEM  | mem_rd held until mem_ready, data captured
// S_RD_PUT  | one sd_buff_wr strobe for the current byte, offset advances
// S_WR_ADDR | present byte offset to the core buffer
// S_WR_WAIT | wait BUF_LAT+1 cycles for buffer data, then latch it
// S_WR_MEM  | mem_wr held until mem_ready, offset advances
// S_DONE    | sd_ack low for one cycle, blk_err on a rejected sector
module sd_block_responder #(
  parameter int ADDR_W  = 24,
  parameter int BUF_LAT = 1,
  parameter int ACK_DLY = 2
) (
  input  logic                clk_sys,
  input  logic                reset,
  sd_block_responder_if.slave bus,
  input  logic [23:0]         img_blocks,
  output logic                busy,
  output logic                blk_err
`ifdef SD_RESP_WRPROTECT_EN
  ,
  input  logic                img_readonly
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_DLY, S_RD_MEM, S_RD_PUT, S_WR_ADDR, S_WR_WAIT, S_WR_MEM, S_DONE
  } state_t;

  localparam logic [7:0] ACK_LOAD  = 8'(ACK_DLY);
  localparam logic [7:0] WAIT_LOAD = 8'(BUF_LAT + 1);

  state_t      state_q, state_d;
  logic [31:0] lba_q;
  logic        dir_rd_q;
  logic        ro_q;
  logic        oob_q;
  logic [9:0]  offset_q;
  logic [9:0]  off_nxt;
  logic [7:0]  cnt_q;
  logic [7:0]  cnt_val;
  logic [7:0]  data_q;
  logic [7:0]  wdata_q;
  logic        ro_in;
  logic        oob_now;
  logic        last;
  logic        skip_wr;

  logic        req_take, oob_ld, cnt_ld, cnt_dec, off_inc, rd_cap, wd_cap;

`ifdef SD_RESP_WRPROTECT_EN
  assign ro_in = img_readonly;
`else
  assign ro_in = 1'b0;
`endif

  // Sector is rejected if past the image end or beyond what mem_addr can reach.
  assign oob_now = (lba_q >= {8'd0, img_blocks}) || (|lba_q[31:ADDR_W-9]);
  // Offset is 10 bits so that 512 is a terminal value rather than a wrap to 0.
  assign off_nxt = offset_q + 10'd1;
  assign last    = off_nxt[9];
  assign skip_wr = oob_q | ro_q;

  assign bus.sd_buff_addr = offset_q[8:0];
  assign bus.sd_buff_dout = data_q;
  assign bus.mem_addr     = {lba_q[ADDR_W-10:0], offset_q[8:0]};
  assign bus.mem_wdata    = wdata_q;
  assign busy             = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk_sys) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state decode, handshake strobes and datapath enables.
  always_comb begin
    state_d         = state_q;
    req_take        = 1'b0;
    oob_ld          = 1'b0;
    cnt_ld          = 1'b0;
    cnt_val         = 8'd0;
    cnt_dec         = 1'b0;
    off_inc         = 1'b0;
    rd_cap          = 1'b0;
    wd_cap          = 1'b0;
    bus.sd_ack      = 1'b0;
    bus.sd_buff_wr  = 1'b0;
    bus.mem_rd      = 1'b0;
    bus.mem_wr      = 1'b0;
    blk_err         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.sd_rd || bus.sd_wr) begin
          req_take = 1'b1;
          cnt_ld   = 1'b1;
          cnt_val  = ACK_LOAD;
          state_d  = S_DLY;
        end
      end
      S_DLY: begin
        if (cnt_q <= 8'd1) begin
          oob_ld = 1'b1;
          if (dir_rd_q) state_d = oob_now ? S_RD_PUT : S_RD_MEM;
          else          state_d = S_WR_ADDR;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_RD_MEM: begin
        bus.sd_ack = 1'b1;
        bus.mem_rd = 1'b1;
        if (bus.mem_ready) begin
          rd_cap  = 1'b1;
          state_d = S_RD_PUT;
        end
      end
      S_RD_PUT: begin
        bus.sd_ack     = 1'b1;
        bus.sd_buff_wr = 1'b1;
        off_inc        = 1'b1;
        if (last)       state_d = S_DONE;
        else if (oob_q) state_d = S_RD_PUT;
        else            state_d = S_RD_MEM;
      end
      S_WR_ADDR: begin
        bus.sd_ack = 1'b1;
        cnt_ld     = 1'b1;
        cnt_val    = WAIT_LOAD;
        state_d    = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        bus.sd_ack = 1'b1;
        if (cnt_q <= 8'd1) begin
          wd_cap = 1'b1;
          if (skip_wr) begin
            off_inc = 1'b1;
            state_d = last ? S_DONE : S_WR_ADDR;
          end else begin
            state_d = S_WR_MEM;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      S_WR_MEM: begin
        bus.sd_ack = 1'b1;
        bus.mem_wr = 1'b1;
        if (bus.mem_ready) begin
          off_inc = 1'b1;
          state_d = last ? S_DONE : S_WR_ADDR;
        end
      end
      S_DONE: begin
        blk_err = oob_q | ro_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, down-counter, byte offset and data holding registers.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      lba_q    <= '0;
      dir_rd_q <= 1'b0;
      ro_q     <= 1'b0;
      oob_q    <= 1'b0;
      offset_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      wdata_q  <= '0;
    end else begin
      if (req_take) begin
        lba_q    <= bus.sd_lba;
        dir_rd_q <= bus.sd_rd;
        ro_q     <= ~bus.sd_rd & ro_in;
        oob_q    <= 1'b0;
        offset_q <= '0;
        data_q   <= '0;
      end
      if (oob_ld)       oob_q <= oob_now;
      if (cnt_ld)       cnt_q <= cnt_val;
      else if (cnt_dec) cnt_q <= cnt_q - 8'd1;
      if (off_inc)      offset_q <= off_nxt;
      if (rd_cap)       data_q <= bus.mem_rdata;
      if (wd_cap)       wdata_q <= bus.sd_buff_din;
    end
  end

endmodule

// File: tb/tb_sd_block_responder.sv
// Randomized bench for sd_block_responder: behavioural image memory and core
// buffer, with a byte-level reference image to predict sector contents.
module tb_sd_block_responder;

  localparam int AW      = 16;
  localparam int ACK_DLY = 2;
  localparam int BUF_LAT = 1;
  localparam int MEM_SZ  = 1 << AW;
  localparam int NSECT   = 1 << (AW - 9);

  logic        clk_sys = 1'b0;
  logic        reset;
  logic [23:0] img_blocks;
  logic        busy;
  logic        blk_err;
  logic        img_readonly;
  logic        mem_init;
  int          mem_lat;
  int          wait_cnt;

  logic [7:0] mem     [0:MEM_SZ-1];
  logic [7:0] ref_mem [0:MEM_SZ-1];
  logic [7:0] core_buf[0:511];
  logic [7:0] rx_buf  [0:511];

  int n_checks = 0;
  int n_errs   = 0;

  // per-transfer monitor counters, cleared on each sd_ack rise
  int cyc = 0, put_cnt = 0, seq_err = 0, rd_cnt = 0, wr_cnt = 0;
  int both_cnt = 0, blk_cnt = 0, min_gap = 1000, addr_chg = 0, exp_addr = 0;
  logic       prev_ack = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
  logic [8:0] prev_addr = '0;

  sd_block_responder_if #(.ADDR_W(AW)) bus ();

  sd_block_responder #(
    .ADDR_W (AW),
    .BUF_LAT(BUF_LAT),
    .ACK_DLY(ACK_DLY)
  ) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .bus         (bus.slave),
    .img_blocks  (img_blocks),
    .busy        (busy),
    .blk_err     (blk_err)
`ifdef SD_RESP_WRPROTECT_EN
    ,
    .img_readonly(img_readonly)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  // image memory: ready pulse after mem_lat extra cycles, write commits on handshake
  always @(posedge clk_sys) begin
    if (mem_init) begin
      for (int a = 0; a < MEM_SZ; a++) mem[a] <= 8'(a[7:0] ^ a[15:8]);
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= 8'h00;
      wait_cnt      <= 0;
    end else if (bus.mem_ready) begin
      if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_ready <= 1'b0;
      wait_cnt      <= 0;
    end else if (bus.mem_rd || bus.mem_wr) begin
      if (wait_cnt >= mem_lat) begin
        bus.mem_ready <= 1'b1;
        bus.mem_rdata <= mem[bus.mem_addr];
      end else begin
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      wait_cnt <= 0;
    end
  end

  // core sector buffer with one cycle read latency
  always @(posedge clk_sys) bus.sd_buff_din <= core_buf[bus.sd_buff_addr];

  // bus monitor
  always @(negedge clk_sys) begin
    cyc++;
    if (bus.sd_ack && !prev_ack) begin
      put_cnt = 0; seq_err = 0; rd_cnt = 0; wr_cnt = 0; both_cnt = 0;
      blk_cnt = 0; min_gap = 1000; addr_chg = cyc; exp_addr = 0;
    end else if (bus.sd_buff_addr != prev_addr) begin
      addr_chg = cyc;
    end
    if (bus.sd_buff_wr) begin
      if (int'(bus.sd_buff_addr) != exp_addr) seq_err++;
      rx_buf[bus.sd_buff_addr] = bus.sd_buff_dout;
      exp_addr++;
      put_cnt++;
    end
    if (bus.mem_rd && !prev_rd) rd_cnt++;
    if (bus.mem_wr && !prev_wr) begin
      wr_cnt++;
      if (cyc - addr_chg < min_gap) min_gap = cyc - addr_chg;
    end
    if (bus.mem_rd && bus.mem_wr) both_cnt++;
    if (blk_err) blk_cnt++;
    prev_ack  = bus.sd_ack;
    prev_rd   = bus.mem_rd;
    prev_wr   = bus.mem_wr;
    prev_addr = bus.sd_buff_addr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One sector request; abort_byte >= 0 resets the DUT once that many bytes have gone out.
  task automatic run_xfer(input bit rd, input bit wr, input logic [31:0] lba,
                          input bit inv_pat, input int abort_byte);
    bit oob, is_rd, ro, write_ok;
    int ack_wait, t, bad, base;
    logic [7:0] exp;
    is_rd = rd;
`ifdef SD_RESP_WRPROTECT_EN
    ro = img_readonly;
`else
    ro = 1'b0;
`endif
    oob = (lba >= 32'(img_blocks)) || (lba >= 32'(NSECT));
    for (int i = 0; i < 512; i++) core_buf[i] = inv_pat ? ~8'(i) : 8'($urandom);

    @(negedge clk_sys);
    bus.sd_lba = lba;
    bus.sd_rd  = rd;
    bus.sd_wr  = wr;
    ack_wait   = 0;
    do begin
      @(negedge clk_sys);
      ack_wait++;
    end while (!bus.sd_ack && ack_wait < 50);
    check("ack_delay", ack_wait - 1, ACK_DLY);
    check("busy_in_xfer", busy, 1);
    bus.sd_rd = 1'b0;
    bus.sd_wr = 1'b0;
    if (!bus.sd_ack) return;

    if (abort_byte >= 0) begin
      t = 0;
      while (put_cnt <= abort_byte && t < 5000) begin
        @(negedge clk_sys);
        t++;
      end
      check("abort_reached", put_cnt > abort_byte, 1);
      reset = 1'b1;
      @(negedge clk_sys);
      check("rst_ack", bus.sd_ack, 0);
      check("rst_mem_rd", bus.mem_rd, 0);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);
      return;
    end

    t = 0;
    while (bus.sd_ack && t < 20000) begin
      @(negedge clk_sys);
      t++;
    end
    check("ack_fall", bus.sd_ack, 0);
    repeat (3) @(negedge clk_sys);
    check("busy_end", busy, 0);

    check("put_count", put_cnt, is_rd ? 512 : 0);
    check("put_order", seq_err, 0);
    check("rd_wr_overlap", both_cnt, 0);
    check("mem_rd_count", rd_cnt, (is_rd && !oob) ? 512 : 0);
    write_ok = !is_rd && !oob && !ro;
    check("mem_wr_count", wr_cnt, write_ok ? 512 : 0);
    check("blk_err_count", blk_cnt, (oob || (!is_rd && ro)) ? 1 : 0);

    if (is_rd) begin
      bad = 0;
      for (int i = 0; i < 512; i++) begin
        exp = oob ? 8'h00 : ref_mem[int'(lba) * 512 + i];
        if (rx_buf[i] !== exp) bad++;
      end
      check("rd_data_bad", bad, 0);
    end
    if (write_ok) begin
      base = int'(lba) * 512;
      for (int i = 0; i < 512; i++) ref_mem[base + i] = core_buf[i];
      bad = 0;
      for (int i = 0; i < 512; i++) if (mem[base + i] !== ref_mem[base + i]) bad++;
      check("wr_data_bad", bad, 0);
      check("wr_gap_ge_lat", min_gap >= BUF_LAT + 1, 1);
    end
  endtask

  initial begin
    int bad;
    reset        = 1'b1;
    mem_init     = 1'b1;
    mem_lat      = 1;
    img_blocks   = 24'd64;
    img_readonly = 1'b0;
    bus.sd_lba   = '0;
    bus.sd_rd    = 1'b0;
    bus.sd_wr    = 1'b0;
    for (int a = 0; a < MEM_SZ; a++) ref_mem[a] = 8'(a[7:0] ^ a[15:8]);
    repeat (3) @(negedge clk_sys);
    mem_init = 1'b0;
    check("rst_strobes", {bus.sd_ack, bus.sd_buff_wr, bus.mem_rd, bus.mem_wr, busy, blk_err}, 0);
    check("rst_buses", {bus.sd_buff_addr, bus.sd_buff_dout, bus.mem_wdata}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    reset = 1'b0;
    @(negedge clk_sys);

    mem_lat = $urandom_range(0, 2);
    run_xfer(1, 0, 32'd3, 0, -1);
    run_xfer(0, 1, 32'd5, 1, -1);
    run_xfer(1, 0, 32'd5, 0, -1);

    img_blocks = 24'd4;
    run_xfer(1, 0, 32'd4, 0, -1);
    run_xfer(0, 1, 32'd4, 0, -1);

    img_blocks = 24'd64;
    run_xfer(1, 1, 32'd7, 0, -1);
    run_xfer(1, 0, 32'd63, 0, -1);
    run_xfer(0, 1, 32'd64, 0, -1);

    img_blocks = 24'd200;
    run_xfer(1, 0, 32'd130, 0, -1);
    img_blocks = 24'hFFFFFF;
    run_xfer(0, 1, 32'h8000_0003, 0, -1);

    img_blocks = 24'd64;
    mem_lat    = 3;
    run_xfer(1, 0, 32'd2, 0, 200);
    run_xfer(1, 0, 32'd0, 0, -1);

    for (int k = 0; k < 5; k++) begin
      bit op_rd;
      img_blocks = 24'($urandom_range(1, 128));
      mem_lat    = $urandom_range(0, 3);
      op_rd      = 1'($urandom_range(0, 1));
      run_xfer(op_rd, !op_rd, 32'($urandom_range(0, 140)), 0, -1);
    end

`ifdef SD_RESP_WRPROTECT_EN
    img_readonly = 1'b1;
    run_xfer(0, 1, 32'd1, 0, -1);
    img_readonly = 1'b0;
`endif

    bad = 0;
    for (int a = 0; a < MEM_SZ; a++) if (mem[a] !== ref_mem[a]) bad++;
    check("mem_final_bad", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
